// File: rtl/ctrl_sequencer_if.sv
// LC-3b decode types and the issue/memory handshake bundle between upstream
// and the control sequencer.

typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
} lc3b_opcode;

typedef enum logic [2:0] {
    alu_add  = 3'd0,
    alu_and  = 3'd1,
    alu_not  = 3'd2,
    alu_pass = 3'd3,
    alu_sll  = 3'd4,
    alu_srl  = 3'd5,
    alu_sra  = 3'd6
} lc3b_aluop;

typedef struct packed {
    lc3b_aluop  aluop;
    logic [2:0] alu_mux_sel;
    logic       load_cc;
    logic       reg_load;
    logic [2:0] regfile_mux_sel;
    logic       dest_mux_sel;
    logic [1:0] pc_mux_sel;
    logic       br_check;
    logic       d_cache_read;
    logic       d_cache_write;
    logic       mem_byte;
    logic       ldi_mux_sel;
    logic [1:0] wdata_mux_sel;
} lc3b_control_word;

interface ctrl_sequencer_if;
    logic             issue_valid;
    lc3b_opcode       opcode;
    logic             bit11;
    logic             bit5;
    logic             bit4;
    logic             stall_in;
    logic             mem_resp;
    lc3b_control_word ctrl;
    logic             ctrl_valid;
    logic             busy;
    logic [1:0]       phase;
    logic             err;

    modport master (
        output issue_valid, opcode, bit11, bit5, bit4, stall_in, mem_resp,
        input  ctrl, ctrl_valid, busy, phase, err
    );

    modport slave (
        input  issue_valid, opcode, bit11, bit5, bit4, stall_in, mem_resp,
        output ctrl, ctrl_valid, busy, phase, err
    );
endinterface

// File: rtl/ctrl_sequencer.sv
// LC-3b control-word sequencer: single-cycle decode plus two-phase ldi/sti.
// Define CTRL_SEQ_TRAP_EN to also sequence trap as a vector fetch + jump.

module ctrl_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input logic            clk,
    input logic            rst,
    ctrl_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IND1 = 2'd1,
        IND2 = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        K_LDI  = 2'd0,
        K_STI  = 2'd1,
        K_TRAP = 2'd2
    } kind_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    kind_t            kind;
    logic [CNT_W-1:0] cnt;

    lc3b_control_word dec_word;
    logic             dec_multi;
    kind_t            dec_kind;
    lc3b_control_word ind2_word;

    // dec_word is the control word for the accepted instruction; for
    // multi-phase ops it is the first (address fetch) phase.
    always_comb begin
        dec_word  = '0;
        dec_multi = 1'b0;
        dec_kind  = K_LDI;
        case (bus.opcode)
            op_add, op_and: begin
                dec_word.aluop       = (bus.opcode == op_and) ? alu_and : alu_add;
                dec_word.alu_mux_sel = bus.bit5 ? 3'b010 : 3'b000;
                dec_word.load_cc     = 1'b1;
                dec_word.reg_load    = 1'b1;
            end
            op_not: begin
                dec_word.aluop    = alu_not;
                dec_word.load_cc  = 1'b1;
                dec_word.reg_load = 1'b1;
            end
            op_br:  dec_word.br_check   = 1'b1;
            op_jmp: dec_word.pc_mux_sel = 2'b10;
            op_jsr: begin
                dec_word.reg_load        = 1'b1;
                dec_word.dest_mux_sel    = 1'b1;
                dec_word.regfile_mux_sel = 3'b011;
                dec_word.pc_mux_sel      = bus.bit11 ? 2'b01 : 2'b10;
            end
            op_ldr: begin
                dec_word.alu_mux_sel     = 3'b011;
                dec_word.d_cache_read    = 1'b1;
                dec_word.regfile_mux_sel = 3'b001;
                dec_word.reg_load        = 1'b1;
                dec_word.load_cc         = 1'b1;
            end
            op_str: begin
                dec_word.alu_mux_sel   = 3'b011;
                dec_word.d_cache_write = 1'b1;
            end
            op_ldb: begin
                dec_word.alu_mux_sel     = 3'b100;
                dec_word.d_cache_read    = 1'b1;
                dec_word.mem_byte        = 1'b1;
                dec_word.regfile_mux_sel = 3'b010;
                dec_word.reg_load        = 1'b1;
                dec_word.load_cc         = 1'b1;
            end
            op_stb: begin
                dec_word.alu_mux_sel   = 3'b100;
                dec_word.d_cache_write = 1'b1;
                dec_word.mem_byte      = 1'b1;
                dec_word.wdata_mux_sel = 2'b10;
            end
            op_lea: begin
                dec_word.regfile_mux_sel = 3'b100;
                dec_word.reg_load        = 1'b1;
                dec_word.load_cc         = 1'b1;
            end
            op_shf: begin
                dec_word.alu_mux_sel = 3'b101;
                dec_word.aluop       = !bus.bit4 ? alu_sll : (bus.bit5 ? alu_sra : alu_srl);
                dec_word.reg_load    = 1'b1;
                dec_word.load_cc     = 1'b1;
            end
            op_ldi: begin
                dec_multi             = 1'b1;
                dec_kind              = K_LDI;
                dec_word.d_cache_read = 1'b1;
                dec_word.alu_mux_sel  = 3'b011;
                dec_word.aluop        = alu_add;
            end
            op_sti: begin
                dec_multi             = 1'b1;
                dec_kind              = K_STI;
                dec_word.d_cache_read = 1'b1;
            end
`ifdef CTRL_SEQ_TRAP_EN
            op_trap: begin
                dec_multi             = 1'b1;
                dec_kind              = K_TRAP;
                dec_word.d_cache_read = 1'b1;
            end
`else
            op_trap: dec_word = '0;
`endif
            default: dec_word = '0;
        endcase
    end

    always_comb begin
        ind2_word = '0;
        case (kind)
            K_LDI: begin
                ind2_word.d_cache_read = 1'b1;
                ind2_word.ldi_mux_sel  = 1'b1;
                ind2_word.reg_load     = 1'b1;
                ind2_word.load_cc      = 1'b1;
            end
            K_STI: begin
                ind2_word.d_cache_write = 1'b1;
                ind2_word.ldi_mux_sel   = 1'b1;
                ind2_word.wdata_mux_sel = 2'b01;
            end
            K_TRAP: begin
                ind2_word.pc_mux_sel   = 2'b11;
                ind2_word.dest_mux_sel = 1'b1;
                ind2_word.reg_load     = 1'b1;
            end
            default: ind2_word = '0;
        endcase
    end

    // Memory phases advance on mem_resp regardless of stall_in; a trap's
    // second phase is a register/PC update and never waits on memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            kind           <= K_LDI;
            cnt            <= '0;
            bus.ctrl       <= '0;
            bus.ctrl_valid <= 1'b0;
            bus.busy       <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            bus.err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.stall_in) begin
                        if (bus.issue_valid) begin
                            bus.ctrl       <= dec_word;
                            bus.ctrl_valid <= 1'b1;
                            if (dec_multi) begin
                                state    <= IND1;
                                kind     <= dec_kind;
                                cnt      <= '0;
                                bus.busy <= 1'b1;
                            end
                        end else begin
                            bus.ctrl_valid <= 1'b0;
                        end
                    end
                end
                IND1, IND2: begin
                    if ((state == IND2 && kind == K_TRAP) ||
                        (state == IND2 && bus.mem_resp)) begin
                        state          <= IDLE;
                        bus.ctrl       <= '0;
                        bus.ctrl_valid <= 1'b0;
                        bus.busy       <= 1'b0;
                    end else if (bus.mem_resp) begin
                        state    <= IND2;
                        cnt      <= '0;
                        bus.ctrl <= ind2_word;
                    end else if (cnt == TO_LAST) begin
                        state          <= IDLE;
                        cnt            <= '0;
                        bus.ctrl       <= '0;
                        bus.ctrl_valid <= 1'b0;
                        bus.busy       <= 1'b0;
                        bus.err        <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state          <= IDLE;
                    bus.ctrl_valid <= 1'b0;
                    bus.busy       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.phase = state;

endmodule
